ama_riscv_icache_resp: RTL and testbench

Instruction-side responder for the front-end fetch handshake: accepts fetch requests on `imem_req`, returns 32-bit instructions on `imem_rsp`, and backs them with a small direct-mapped cache that refills whole lines from a line-wide backing memory port. It sits between the front-end controller and instruction memory. It owns `imem_req.ready`, which the front end reads as "icache stalled/not stalled", and `imem_rsp.valid`, which ends front-end icache stalls.

---
 rtl/ama_riscv_icache_resp.sv | 221 ++++++++++++++++++++++
 tb/tb_ama_riscv_icache_resp.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_icache_resp.sv
// Instruction-side fetch responder backed by a direct-mapped cache with
// whole-line refills from a line-wide backing memory port.
module ama_riscv_icache_resp #(
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    // fetch request from the front end
    input  logic                       imem_req_valid_i,
    output logic                       imem_req_ready_o,
    input  logic [31:0]                imem_req_data_i,
    // instruction response to the front end
    output logic                       imem_rsp_valid_o,
    input  logic                       imem_rsp_ready_i,
    output logic [31:0]                imem_rsp_data_o,
    // line refill request to backing memory
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [31:0]                mem_req_data_o,
    // line refill response from backing memory
    input  logic                       mem_rsp_valid_i,
    output logic                       mem_rsp_ready_o,
    input  logic [32*LINE_WORDS-1:0]   mem_rsp_data_i,
    // maintenance and statistics
    input  logic                       inv_all_i,
    output logic [31:0]                hit_cnt_o,
    output logic [31:0]                miss_cnt_o
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = 32 - 2 - OFF_W - IDX_W;
    localparam int unsigned LINE_W = 32 * LINE_WORDS;

    // word-granular fetch address split into tag / index / offset
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } fetch_addr_t;

    typedef enum logic [1:0] {
        ST_READY,
        ST_MISS_REQ,
        ST_MISS_WAIT,
        ST_REFILL_RSP
    } state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [LINE_W-1:0]  data_q [SETS];
    fetch_addr_t        addr_q, addr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               mreq_valid_q, mreq_valid_d;
    logic [31:0]        mreq_data_q, mreq_data_d;
    logic               mrsp_ready_q, mrsp_ready_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;
    logic               inv_pend_q, inv_pend_d;

    fetch_addr_t        req_addr;
    logic [LINE_W-1:0]  lookup_line;
    logic [31:0]        lookup_word;
    logic [31:0]        refill_word;
    logic               lookup_hit;
    logic               req_acc;
    logic               refill_we;
    logic               unused_byte_off;

    assign req_addr        = fetch_addr_t'(imem_req_data_i[31:2]);
    assign unused_byte_off = ^imem_req_data_i[1:0];

    // Only READY and the one-cycle REFILL_RSP accept, and only once any
    // outstanding response is gone or being consumed this cycle.
    assign imem_req_ready_o = ((state_q == ST_READY) || (state_q == ST_REFILL_RSP)) &&
                              (!rsp_valid_q || imem_rsp_ready_i);
    assign req_acc = imem_req_valid_i && imem_req_ready_o;

    // Same-cycle tag compare and word select on the incoming address
    always_comb begin
        lookup_line = data_q[req_addr.idx];
        lookup_hit  = valid_q[req_addr.idx] && (tag_q[req_addr.idx] == req_addr.tag);
        lookup_word = '0;
        for (int w = 0; w < int'(LINE_WORDS); w++) begin
            if (OFF_W'(w) == req_addr.off) begin
                lookup_word = lookup_line[w*32 +: 32];
            end
        end
    end

    // Pick the requested word straight out of the incoming refill line
    always_comb begin
        refill_word = '0;
        for (int w = 0; w < int'(LINE_WORDS); w++) begin
            if (OFF_W'(w) == addr_q.off) begin
                refill_word = mem_rsp_data_i[w*32 +: 32];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        rsp_valid_d  = rsp_valid_q && !imem_rsp_ready_i;
        rsp_data_d   = rsp_data_q;
        mreq_valid_d = mreq_valid_q;
        mreq_data_d  = mreq_data_q;
        mrsp_ready_d = mrsp_ready_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        inv_pend_d   = inv_pend_q;
        refill_we    = 1'b0;

        case (state_q)
            ST_READY, ST_REFILL_RSP: begin
                if (state_q == ST_REFILL_RSP) begin
                    state_d    = ST_READY;
                    inv_pend_d = 1'b0;
                    if (inv_pend_q) begin
                        valid_d = '0;
                    end
                end
                if (inv_all_i) begin
                    valid_d = '0;
                end
                if (req_acc) begin
                    addr_d = req_addr;
                    if (lookup_hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = lookup_word;
                        hit_cnt_d   = hit_cnt_q + 32'd1;
                        state_d     = ST_READY;
                    end else begin
                        rsp_valid_d  = 1'b0;
                        miss_cnt_d   = miss_cnt_q + 32'd1;
                        mreq_valid_d = 1'b1;
                        mreq_data_d  = {req_addr.tag, req_addr.idx, (OFF_W+2)'(0)};
                        state_d      = ST_MISS_REQ;
                    end
                end
            end
            ST_MISS_REQ: begin
                if (inv_all_i) begin
                    inv_pend_d = 1'b1;
                end
                if (mreq_valid_q && mem_req_ready_i) begin
                    mreq_valid_d = 1'b0;
                    mrsp_ready_d = 1'b1;
                    state_d      = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                if (inv_all_i) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_rsp_valid_i && mrsp_ready_q) begin
                    refill_we             = 1'b1;
                    valid_d[addr_q.idx]   = 1'b1;
                    mrsp_ready_d          = 1'b0;
                    rsp_valid_d           = 1'b1;
                    rsp_data_d            = refill_word;
                    state_d               = ST_REFILL_RSP;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Control state, valid bits, outputs and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_READY;
            valid_q      <= '0;
            addr_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            mreq_valid_q <= 1'b0;
            mreq_data_q  <= '0;
            mrsp_ready_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            inv_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_data_q  <= mreq_data_d;
            mrsp_ready_q <= mrsp_ready_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            inv_pend_q   <= inv_pend_d;
        end
    end

    // Tag and line storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (refill_we) begin
            tag_q[addr_q.idx]  <= addr_q.tag;
            data_q[addr_q.idx] <= mem_rsp_data_i;
        end
    end

    assign imem_rsp_valid_o = rsp_valid_q;
    assign imem_rsp_data_o  = rsp_data_q;
    assign mem_req_valid_o  = mreq_valid_q;
    assign mem_req_data_o   = mreq_data_q;
    assign mem_rsp_ready_o  = mrsp_ready_q;
    assign hit_cnt_o        = hit_cnt_q;
    assign miss_cnt_o       = miss_cnt_q;

endmodule

// File: tb/tb_ama_riscv_icache_resp.sv
// Bench for ama_riscv_icache_resp: directed fetch sequences, a behavioural
// cache/memory model, and a per-cycle compare process.
module tb_ama_riscv_icache_resp;

    localparam int unsigned SETS       = 16;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

    logic                     clk;
    logic                     rst;
    logic                     imem_req_valid_i;
    logic                     imem_req_ready_o;
    logic [31:0]              imem_req_data_i;
    logic                     imem_rsp_valid_o;
    logic                     imem_rsp_ready_i;
    logic [31:0]              imem_rsp_data_o;
    logic                     mem_req_valid_o;
    logic                     mem_req_ready_i;
    logic [31:0]              mem_req_data_o;
    logic                     mem_rsp_valid_i;
    logic                     mem_rsp_ready_o;
    logic [32*LINE_WORDS-1:0] mem_rsp_data_i;
    logic                     inv_all_i;
    logic [31:0]              hit_cnt_o;
    logic [31:0]              miss_cnt_o;

    ama_riscv_icache_resp #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_i (imem_req_valid_i),
        .imem_req_ready_o (imem_req_ready_o),
        .imem_req_data_i  (imem_req_data_i),
        .imem_rsp_valid_o (imem_rsp_valid_o),
        .imem_rsp_ready_i (imem_rsp_ready_i),
        .imem_rsp_data_o  (imem_rsp_data_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_data_o   (mem_req_data_o),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_ready_o  (mem_rsp_ready_o),
        .mem_rsp_data_i   (mem_rsp_data_i),
        .inv_all_i        (inv_all_i),
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- behavioural model ----------------
    bit          m_valid [SETS];
    int unsigned m_tag   [SETS];
    logic [31:0] exp_q [$];
    logic [31:0] exp_hit  = 0;
    logic [31:0] exp_miss = 0;
    logic [31:0] exp_line = 0;
    int          mem_delay = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a / 32'd4) * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    function automatic logic [32*LINE_WORDS-1:0] make_line(input logic [31:0] la);
        logic [32*LINE_WORDS-1:0] l;
        for (int w = 0; w < int'(LINE_WORDS); w++) begin
            l[w*32 +: 32] = mem_word(la + 32'(w * 4));
        end
        return l;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // One accepted request / one invalidate pulse, applied in that order.
    task automatic model_step(input bit acc, input logic [31:0] a, input bit inv);
        int unsigned line_no, idx, tag;
        bit hit;
        hit = 1'b0;
        line_no = a / LINE_BYTES;
        idx = line_no % SETS;
        tag = line_no / SETS;
        if (acc) begin
            hit = m_valid[idx] && (m_tag[idx] == tag);
            exp_q.push_back(mem_word(a & 32'hFFFF_FFFC));
            if (hit) exp_hit = exp_hit + 32'd1;
            else begin
                exp_miss = exp_miss + 32'd1;
                exp_line = line_no * LINE_BYTES;
            end
        end
        if (inv) begin
            for (int s = 0; s < int'(SETS); s++) m_valid[s] = 1'b0;
        end
        if (acc && !hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < int'(SETS); s++) m_valid[s] = 1'b0;
        exp_q.delete();
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    // ---------------- compare process ----------------
    bit          held;
    logic [31:0] held_data;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            check("hit_cnt", hit_cnt_o, exp_hit);
            check("miss_cnt", miss_cnt_o, exp_miss);
            if (held) begin
                check("hold_valid", {31'b0, imem_rsp_valid_o}, 32'd1);
                check("hold_data", imem_rsp_data_o, held_data);
            end
            if (imem_rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_rsp: got data 0x%08h expected no response at %0t",
                             imem_rsp_data_o, $time);
                end else if (imem_rsp_ready_i) begin
                    check("rsp_data", imem_rsp_data_o, exp_q.pop_front());
                end
            end
            if (mem_req_valid_o) begin
                check("mem_req_data", mem_req_data_o, exp_line);
            end
            held      = imem_rsp_valid_o && !imem_rsp_ready_i;
            held_data = imem_rsp_data_o;
        end
    end

    // ---------------- backing memory responder ----------------
    initial begin
        logic [31:0] line_a;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_valid_o && mem_req_ready_i) begin
                line_a = mem_req_data_o;
                @(posedge clk);
                for (int i = 0; i < mem_delay; i++) @(posedge clk);
                #2;
                if (!rst) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_data_i  = make_line(line_a);
                    for (int k = 0; k < 100; k++) begin
                        @(negedge clk);
                        if (rst || mem_rsp_ready_o) break;
                    end
                    @(posedge clk);
                    #2 mem_rsp_valid_i = 1'b0;
                end
            end
        end
    end

    // ---------------- front-end driver ----------------
    bit          rdy_s, mrsp_rdy_s, rsp_v_s, mreq_v_s;
    logic [31:0] rsp_d_s, mreq_d_s, hit_s, miss_s;

    // Entered just after a rising edge; returns just after the next one.
    task automatic drive_cycle(input bit v, input logic [31:0] a, input bit rr,
                               input bit inv, output bit acc);
        #2;
        imem_req_valid_i = v;
        imem_req_data_i  = a;
        imem_rsp_ready_i = rr;
        inv_all_i        = inv;
        #1;
        rdy_s      = imem_req_ready_o;
        mrsp_rdy_s = mem_rsp_ready_o;
        acc        = v && imem_req_ready_o;
        @(negedge clk);
        rsp_v_s  = imem_rsp_valid_o;
        rsp_d_s  = imem_rsp_data_o;
        mreq_v_s = mem_req_valid_o;
        mreq_d_s = mem_req_data_o;
        hit_s    = hit_cnt_o;
        miss_s   = miss_cnt_o;
        @(posedge clk);
        model_step(acc, a, inv);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic fetch(input logic [31:0] a);
        bit acc;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b1, a, 1'b1, 1'b0, acc);
            if (acc) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL fetch_timeout: request 0x%08h never accepted", a);
    endtask

    // Counts cycles after the accepting edge until a response is visible.
    task automatic wait_rsp(input int start, output int lat);
        bit acc;
        lat = start;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
            lat++;
            if (rsp_v_s) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_timeout: got no response expected one within 50 cycles");
    endtask

    initial begin
        bit acc;
        int lat;
        rst              = 1'b1;
        imem_req_valid_i = 1'b0;
        imem_req_data_i  = '0;
        imem_rsp_ready_i = 1'b1;
        mem_req_ready_i  = 1'b1;
        inv_all_i        = 1'b0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, imem_req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'b0, imem_rsp_valid_o}, 32'd0);
        check("rst_rsp_data", imem_rsp_data_o, 32'h0);
        check("rst_mem_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
        check("rst_mem_rsp_ready", {31'b0, mem_rsp_ready_o}, 32'd0);
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);

        // Cold boot: first fetch misses, 2-cycle memory
        mem_delay = 2;
        fetch(32'h0);
        idle(1);
        check("cold_mem_req_valid", {31'b0, mreq_v_s}, 32'd1);
        check("cold_mem_req_addr", mreq_d_s, 32'h0);
        wait_rsp(1, lat);
        check("cold_latency", 32'(lat), 32'd5);
        check("cold_word0", rsp_d_s, 32'h1234_5678);
        check("cold_miss_cnt", miss_s, 32'd1);

        // Hit streaming: three back-to-back hits
        drive_cycle(1'b1, 32'h4, 1'b1, 1'b0, acc);
        check("stream_acc0", {31'b0, acc}, 32'd1);
        drive_cycle(1'b1, 32'h8, 1'b1, 1'b0, acc);
        check("stream_acc1", {31'b0, acc}, 32'd1);
        check("stream_rsp0_valid", {31'b0, rsp_v_s}, 32'd1);
        check("stream_word1", rsp_d_s, 32'hB06B_D031);
        drive_cycle(1'b1, 32'hC, 1'b1, 1'b0, acc);
        check("stream_acc2", {31'b0, acc}, 32'd1);
        check("stream_rsp1_valid", {31'b0, rsp_v_s}, 32'd1);
        check("stream_word2", rsp_d_s, 32'h4EA3_49EA);
        idle(1);
        check("stream_rsp2_valid", {31'b0, rsp_v_s}, 32'd1);
        check("stream_hit_cnt", hit_s, 32'd3);
        idle(1);
        check("stream_done", {31'b0, rsp_v_s}, 32'd0);

        // Backpressure: hold a hit for 3 cycles, then consume it while
        // accepting the next request in the same cycle
        drive_cycle(1'b1, 32'h4, 1'b0, 1'b0, acc);
        check("bp_acc", {31'b0, acc}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
            check("bp_req_ready", {31'b0, rdy_s}, 32'd0);
            check("bp_rsp_valid", {31'b0, rsp_v_s}, 32'd1);
        end
        drive_cycle(1'b1, 32'h8, 1'b1, 1'b0, acc);
        check("bp_replace_acc", {31'b0, acc}, 32'd1);
        idle(2);
        check("bp_hit_cnt", hit_s, 32'd5);

        // Conflict miss with a zero-wait memory, then invalidate
        mem_delay = 0;
        fetch(32'h100);
        idle(1);
        check("conf_mem_req_addr", mreq_d_s, 32'h100);
        wait_rsp(1, lat);
        check("conf_latency", 32'(lat), 32'd3);
        fetch(32'h0);
        wait_rsp(0, lat);
        fetch(32'h4);
        idle(1);
        check("conf_refetch_hit", hit_s, 32'd6);
        check("conf_miss_cnt", miss_s, 32'd3);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, acc);
        fetch(32'h4);
        wait_rsp(0, lat);
        check("inv_miss_cnt", miss_s, 32'd4);
        drive_cycle(1'b1, 32'h8, 1'b1, 1'b1, acc);
        check("inv_same_acc", {31'b0, acc}, 32'd1);
        idle(1);
        check("inv_same_cycle_hit", hit_s, 32'd7);
        fetch(32'h8);
        wait_rsp(0, lat);
        check("inv_after_miss", miss_s, 32'd5);

        // Invalidate while waiting for the refill
        mem_delay = 3;
        fetch(32'h20);
        idle(2);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, acc);
        check("wait_mem_rsp_ready", {31'b0, mrsp_rdy_s}, 32'd1);
        wait_rsp(3, lat);
        check("refill_inv_latency", 32'(lat), 32'd6);
        idle(1);
        fetch(32'h20);
        wait_rsp(0, lat);
        idle(1);
        check("refill_inv_miss_cnt", miss_s, 32'd7);

        // Reset while a refill request is outstanding
        mem_req_ready_i = 1'b0;
        fetch(32'h40);
        idle(1);
        check("midmiss_req_valid", {31'b0, mreq_v_s}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midmiss_req_valid_rst", {31'b0, mem_req_valid_o}, 32'd0);
        check("midmiss_rsp_ready_rst", {31'b0, mem_rsp_ready_o}, 32'd0);
        check("midmiss_rsp_valid_rst", {31'b0, imem_rsp_valid_o}, 32'd0);
        check("midmiss_req_ready_rst", {31'b0, imem_req_ready_o}, 32'd1);
        check("midmiss_miss_cnt_rst", miss_cnt_o, 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        mem_req_ready_i = 1'b1;
        mem_delay = 1;
        @(posedge clk);
        fetch(32'h0);
        wait_rsp(0, lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        fetch(32'h4);
        idle(2);
        check("post_rst_miss_cnt", miss_s, 32'd1);
        check("post_rst_hit_cnt", hit_s, 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
